// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I ALU-class instructions into ALU operation/X/Y,
// presented through a valid/ready output register backed by a one-entry skid buffer.
module alu_issue_stage #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] ILLEGAL_OP = 4'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_operation,
  output logic [DATA_WIDTH-1:0] out_x,
  output logic [DATA_WIDTH-1:0] out_y,
  output logic [4:0]            out_rd,
  output logic                  out_illegal
);
  if (DATA_WIDTH != 32) begin : g_width_check
    $error("alu_issue_stage supports only DATA_WIDTH=32");
  end
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_OR = 4'd2, OP_XOR = 4'd3, OP_AND = 4'd4;
  localparam logic [3:0] OP_SLTU = 4'd5, OP_SLT = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8, OP_SLL = 4'd9;
  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    logic        ill;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t      state_q;
  entry_t      out_q, skid_q, dec;
  logic        out_valid_q, in_ready_q;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [3:0]  base_op;
  logic [4:0]  rd;
  logic        alt, shift, in_xfer, out_xfer;
  assign opc      = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign rd       = in_instr[11:7];
  assign alt      = f7 == 7'b0100000;
  assign shift    = f3[1:0] == 2'b01;
  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;
  always_comb begin
    base_op = OP_ADD;
    case (f3)
      3'b001:  base_op = OP_SLL;
      3'b010:  base_op = OP_SLT;
      3'b011:  base_op = OP_SLTU;
      3'b100:  base_op = OP_XOR;
      3'b101:  base_op = OP_SRL;
      3'b110:  base_op = OP_OR;
      3'b111:  base_op = OP_AND;
      default: base_op = OP_ADD;
    endcase
  end
  // Anything not explicitly matched below stays an illegal entry with rd preserved.
  always_comb begin
    dec = '{op: ILLEGAL_OP, x: 32'h0, y: 32'h0, rd: rd, ill: 1'b1};
    case (opc)
      7'b0110011:
        if (f7 == 7'b0 || (alt && (f3 == 3'b000 || f3 == 3'b101)))
          dec = '{op: alt ? (f3 == 3'b000 ? OP_SUB : OP_SRA) : base_op,
                  x: in_rs1, y: in_rs2, rd: rd, ill: 1'b0};
      7'b0010011:
        if (!shift)
          dec = '{op: base_op, x: in_rs1, y: {{20{in_instr[31]}}, in_instr[31:20]}, rd: rd, ill: 1'b0};
        else if (f7 == 7'b0 || (alt && f3[2]))
          dec = '{op: alt ? OP_SRA : base_op, x: in_rs1, y: {27'h0, in_instr[24:20]}, rd: rd, ill: 1'b0};
      7'b0110111: dec = '{op: OP_ADD, x: 32'h0, y: {in_instr[31:12], 12'h0}, rd: rd, ill: 1'b0};
      7'b0010111: dec = '{op: OP_ADD, x: in_pc, y: {in_instr[31:12], 12'h0}, rd: rd, ill: 1'b0};
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_q       <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY:
          if (in_xfer) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        ONE:
          if (in_xfer && out_xfer) begin
            out_q <= dec;
          end else if (in_xfer) begin
            skid_q     <= dec;
            in_ready_q <= 1'b0;
            state_q    <= FULL;
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        FULL:
          if (out_xfer) begin
            out_q      <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        default: state_q <= EMPTY;
      endcase
    end
  end
  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_operation = out_q.op;
  assign out_x         = out_q.x;
  assign out_y         = out_q.y;
  assign out_rd        = out_q.rd;
  assign out_illegal   = out_q.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed decode vectors, skid/backpressure ordering and async reset checks.
module tb_alu_issue_stage;
  logic        clk = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_illegal;
  logic [31:0] in_instr = '0, in_pc = '0, in_rs1 = '0, in_rs2 = '0, out_x, out_y;
  logic [3:0]  out_operation;
  logic [4:0]  out_rd;
  int          errors = 0, checks = 0;
  alu_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_valid(out_valid), .out_ready(out_ready), .out_operation(out_operation),
    .out_x(out_x), .out_y(out_y), .out_rd(out_rd), .out_illegal(out_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] instr, pc, rs1, rs2);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    in_rs1   = rs1;
    in_rs2   = rs2;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic expect_out(input string tag, input logic [3:0] op, input logic [31:0] x, y,
                            input logic [4:0] rd, input logic ill);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".op"}, 32'(out_operation), 32'(op));
    chk({tag, ".x"}, out_x, x);
    chk({tag, ".y"}, out_y, y);
    chk({tag, ".rd"}, 32'(out_rd), 32'(rd));
    chk({tag, ".ill"}, 32'(out_illegal), 32'(ill));
  endtask
  initial begin
    #12;
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.ready", 32'(in_ready), 32'd1);
    chk("rst.x", out_x, 32'h0);
    reset = 1'b0;
    chk("rel.ready", 32'(in_ready), 32'd1);
    send(32'h002081B3, 32'h0, 32'd5, 32'd7);
    expect_out("add", 4'd0, 32'd5, 32'd7, 5'd3, 1'b0);
    send(32'h402081B3, 32'h0, 32'd9, 32'd4);
    expect_out("sub", 4'd1, 32'd9, 32'd4, 5'd3, 1'b0);
    send(32'h40335293, 32'h0, 32'h80000000, 32'h0);
    expect_out("srai", 4'd8, 32'h80000000, 32'd3, 5'd5, 1'b0);
    send(32'hFFF00093, 32'h0, 32'h0, 32'h0);
    expect_out("addi", 4'd0, 32'h0, 32'hFFFFFFFF, 5'd1, 1'b0);
    send(32'h123450B7, 32'h0, 32'h55, 32'h66);
    expect_out("lui", 4'd0, 32'h0, 32'h12345000, 5'd1, 1'b0);
    send(32'h00001097, 32'h100, 32'h55, 32'h66);
    expect_out("auipc", 4'd0, 32'h100, 32'h1000, 5'd1, 1'b0);
    send(32'h022081B3, 32'h0, 32'd5, 32'd7);
    expect_out("mul", 4'd0, 32'h0, 32'h0, 5'd3, 1'b1);
    send(32'h00012083, 32'h0, 32'd5, 32'd7);
    expect_out("load", 4'd0, 32'h0, 32'h0, 5'd1, 1'b1);
    send(32'h402091B3, 32'h0, 32'd5, 32'd7);
    expect_out("sll_alt", 4'd0, 32'h0, 32'h0, 5'd3, 1'b1);
    send(32'h40309093, 32'h0, 32'd5, 32'd7);
    expect_out("slli_alt", 4'd0, 32'h0, 32'h0, 5'd1, 1'b1);
    send(32'h0020F1B3, 32'h0, 32'hF0, 32'h3C);
    expect_out("and", 4'd4, 32'hF0, 32'h3C, 5'd3, 1'b0);
    send(32'h0050D193, 32'h0, 32'h80, 32'h0);
    expect_out("srli", 4'd7, 32'h80, 32'd5, 5'd3, 1'b0);
    tick();
    chk("drain.valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd1, 32'd0);
    expect_out("A", 4'd0, 32'd1, 32'd0, 5'd3, 1'b0);
    chk("one.ready", 32'(in_ready), 32'd1);
    send(32'h002081B3, 32'h0, 32'd2, 32'd0);
    chk("full.x", out_x, 32'd1);
    chk("full.ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_rs1   = 32'd3;
    tick();
    chk("hold.x", out_x, 32'd1);
    chk("hold.ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    expect_out("B", 4'd0, 32'd2, 32'd0, 5'd3, 1'b0);
    chk("B.ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    expect_out("C", 4'd0, 32'd3, 32'd0, 5'd3, 1'b0);
    tick();
    chk("C.drain", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd8, 32'd8);
    send(32'h002081B3, 32'h0, 32'd9, 32'd9);
    chk("prerst.ready", 32'(in_ready), 32'd0);
    #1 reset = 1'b1;
    #1;
    chk("arst.valid", 32'(out_valid), 32'd0);
    chk("arst.ready", 32'(in_ready), 32'd1);
    chk("arst.x", out_x, 32'h0);
    chk("arst.y", out_y, 32'h0);
    chk("arst.rd", 32'(out_rd), 32'd0);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    send(32'h002081B3, 32'h0, 32'd5, 32'd7);
    expect_out("post", 4'd0, 32'd5, 32'd7, 5'd3, 1'b0);
    tick();
    chk("post.noskid", 32'(out_valid), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
